// File: rtl/serial_bit_reverser8.sv
// Handshaked serial bit-order engine: accepts a word, shifts it LSB-first through
// a serial path, and rebuilds it bit-reversed (mode=1) or in original order (mode=0).
module serial_bit_reverser8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_src;
  logic [WIDTH-1:0] r_dst;
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_dst_next;
  logic             w_last;

  // Reverse appends at the LSB so the first bit out ends at the MSB; pass
  // inserts at the MSB so the first bit out lands back at bit 0.
  assign w_dst_next = r_mode ? {r_dst[WIDTH-2:0], r_src[0]}
                             : {r_src[0], r_dst[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would make r_dst see the shifted r_src.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_dout      <= '0;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_src   <= din;
            r_mode  <= mode;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_src <= r_src >> 1;
          r_dst <= w_dst_next;
          if (w_last) begin
            r_dout      <= w_dst_next;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_bit_reverser8.sv
// Directed bench for serial_bit_reverser8: latency, ordering, backpressure,
// ignored input while busy, asynchronous abort, and a reverse-reverse chain.
module tb_serial_bit_reverser8;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  logic [W-1:0] ch_din;
  logic         ch_valid;
  logic         a_ready;
  logic [W-1:0] a_dout;
  logic         a_valid;
  logic         a_busy;
  logic         b_ready;
  logic [W-1:0] b_dout;
  logic         b_valid;
  logic         b_busy;
  logic         b_out_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] sb[$];

  serial_bit_reverser8 #(.WIDTH(W), .CNT_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  serial_bit_reverser8 #(.WIDTH(W), .CNT_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .din(ch_din), .mode(1'b1), .in_valid(ch_valid),
    .in_ready(a_ready), .dout(a_dout), .out_valid(a_valid),
    .out_ready(b_ready), .busy(a_busy)
  );

  serial_bit_reverser8 #(.WIDTH(W), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .din(a_dout), .mode(1'b1), .in_valid(a_valid),
    .in_ready(b_ready), .dout(b_dout), .out_valid(b_valid),
    .out_ready(b_out_ready), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[W-1-i];
    return m ? r : d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word into the main DUT; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] d, input logic m);
    @(negedge clk);
    check("in_ready_before_send", in_ready, 1);
    din      = d;
    mode     = m;
    in_valid = 1'b1;
    sb.push_back(model(d, m));
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  // Counts edges after the accept edge until out_valid, then compares dout to the scoreboard.
  task automatic receive(input string tag);
    int lat;
    logic [W-1:0] exp;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, W);
    exp = sb.pop_front();
    check({tag, "_dout"}, dout, exp);
    check({tag, "_in_ready_hold"}, in_ready, 0);
  endtask

  initial begin
    int lat;
    logic stable;
    logic [W-1:0] held;
    logic seen;

    rst_n = 1'b0; din = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ch_din = '0; ch_valid = 1'b0; b_out_ready = 1'b1;

    // 1: reset state and a single reversed word
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1 check("in_ready_after_release", in_ready, 1);
    send(8'b10101010, 1'b1);
    receive("t1");
    check("t1_value", dout, 8'b01010101);
    @(negedge clk);
    check("t1_drained", out_valid, 0);
    check("t1_busy_low", busy, 0);
    check("t1_in_ready", in_ready, 1);

    // 2: back-to-back words with mixed modes
    send(8'b11110000, 1'b1);
    receive("t2a");
    @(negedge clk);
    check("t2a_in_ready", in_ready, 1);
    send(8'b00001111, 1'b1);
    receive("t2b");
    @(negedge clk);
    check("t2b_in_ready", in_ready, 1);
    send(8'b11001100, 1'b0);
    receive("t2c");
    @(negedge clk);
    check("t2c_in_ready", in_ready, 1);

    // 3: backpressure holds a palindrome for 20 cycles, then one transfer
    out_ready = 1'b0;
    send(8'b10011001, 1'b1);
    receive("t3");
    held   = dout;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || dout !== held || in_ready) stable = 1'b0;
    end
    check("t3_held_stable", stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_single_transfer", out_valid, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t3_no_repeat", seen, 0);

    // 4: input traffic during SHIFT is ignored
    send(8'b00110011, 1'b1);
    din = 8'hFF; mode = 1'b0; in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("t4_latency", lat, W);
    check("t4_dout", dout, sb.pop_front());
    check("t4_value", dout, 8'b11001100);
    seen = 1'b0;
    @(negedge clk);
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("t4_no_extra_output", seen, 0);

    // 5: asynchronous reset mid-SHIFT aborts the word
    send(8'b11110000, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_dout_zero", dout, 0);
    check("t5_out_valid_zero", out_valid, 0);
    check("t5_busy_zero", busy, 0);
    check("t5_in_ready_zero", in_ready, 0);
    sb.delete();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t5_no_output", seen, 0);
    rst_n = 1'b1;
    send(8'b10101010, 1'b1);
    receive("t5_after");
    check("t5_value", dout, 8'b01010101);
    @(negedge clk);

    // 6: reverse-then-reverse chain restores every 8-bit value
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      ch_din   = W'(v);
      ch_valid = 1'b1;
      sb.push_back(W'(v));
      @(negedge clk);
      ch_valid = 1'b0;
      lat = 0;
      while (!b_valid && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check("t6_chain_timeout", (lat < 60), 1);
      check("t6_chain_dout", b_dout, sb.pop_front());
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
